// File: rtl/cpu_dbg_pkg.sv
// ----------------------------------------------------------------------------
// cpu_dbg_pkg
//
// Shared definitions for the CPU debug run/step/halt control path. The PC
// controller produces `state` with this encoding and the debug display unit
// decodes it with the same constants, so both sides stay in lock-step.
//
// Contents:
//   ST_HALT / ST_RUN / ST_STEP  - 2-bit controller state encoding
//   DEFAULT_RESET_PC            - PC loaded by reset unless overridden
//   step_load()                 - instruction count latched on a step request
// ----------------------------------------------------------------------------
package cpu_dbg_pkg;

    // Controller state encoding. 2'd3 is unused and always recovers to HALT.
    localparam logic [1:0] ST_HALT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STEP = 2'd2;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // A step request for zero instructions still executes one instruction.
    function automatic logic [7:0] step_load(input logic [7:0] num);
        return (num == 8'd0) ? 8'd1 : num;
    endfunction

endpackage : cpu_dbg_pkg

// File: rtl/pc_step_ctrl.sv
// ----------------------------------------------------------------------------
// pc_step_ctrl
//
// Program-counter register with debug run/step/halt control for the
// single-cycle CPU. The PC advances to the next-PC value only in cycles where
// the debug controller lets the current instruction commit; the same commit
// strobe gates the register-file and data-memory writes, and every commit is
// counted in a retired-instruction counter for the debug display.
//
// Parameters:
//   RESET_PC  - PC value loaded by reset
//   CNT_W     - width of the retired-instruction counter (wraps modulo 2^CNT_W)
//
// Ports:
//   clk        in   system clock, all state updates on the rising edge
//   rst        in   synchronous active-high reset, overrides all other inputs
//   next_pc    in   next-PC from the next-PC adder/mux, valid every cycle
//   run        in   one-cycle pulse: free-run request
//   step       in   one-cycle pulse: execute step_num instructions
//   halt       in   one-cycle pulse: stop request
//   step_num   in   instructions per step request (0 treated as 1)
//   bp_en      in   breakpoint enable
//   bp_addr    in   breakpoint PC, word address in bits [31:2]
//   cur_pc     out  current PC, feeds instruction memory and next-PC logic
//   commit     out  instruction at cur_pc commits this cycle
//   state      out  controller state (cpu_dbg_pkg encoding)
//   bp_hit     out  set when RUN stopped on a breakpoint, cleared on leaving HALT
//   instr_cnt  out  retired instructions since reset
// ----------------------------------------------------------------------------
module pc_step_ctrl
    import cpu_dbg_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      next_pc,
    input  logic             run,
    input  logic             step,
    input  logic             halt,
    input  logic [7:0]       step_num,
    input  logic             bp_en,
    input  logic [31:0]      bp_addr,
    output logic [31:0]      cur_pc,
    output logic             commit,
    output logic [1:0]       state,
    output logic             bp_hit,
    output logic [CNT_W-1:0] instr_cnt
);

    // ------------------------------------------------------------------------
    // Registers and internal wires
    // ------------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [7:0]       r_remaining;   // instructions left in the current step
    logic             r_skip_bp;     // suppress breakpoint on first RUN cycle
    logic             r_bp_hit;
    logic [31:0]      r_cur_pc;
    logic [CNT_W-1:0] r_instr_cnt;

    logic             w_commit;
    logic             w_bp_match;
    logic             w_leave_halt;

    // The PC is always word aligned, so the byte-offset bits of the next-PC
    // and breakpoint address are intentionally ignored.
    logic             w_unused_bits;
    assign w_unused_bits = ^{next_pc[1:0], bp_addr[1:0]};

    // Breakpoint compare on word address. skip_bp masks it for the first RUN
    // cycle so that resuming from a breakpoint PC executes that instruction
    // instead of stopping on it again.
    assign w_bp_match = bp_en
                     && (r_cur_pc[31:2] == bp_addr[31:2])
                     && !r_skip_bp;

    assign w_leave_halt = (r_state == ST_HALT) && (w_next_state != ST_HALT);

    // ------------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_HALT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // FSM process 2: next-state logic
    // ------------------------------------------------------------------------
    // NOTE: the default assignment first keeps this block purely
    // combinational; a missed branch would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_HALT: begin
                // step wins over run when both arrive together; halt is a no-op
                if (step) begin
                    w_next_state = ST_STEP;
                end else if (run) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (halt || w_bp_match) begin
                    w_next_state = ST_HALT;
                end
            end
            ST_STEP: begin
                // The commit that consumes the last remaining instruction
                // ends the step.
                if (halt || (r_remaining == 8'd1)) begin
                    w_next_state = ST_HALT;
                end
            end
            default: begin
                w_next_state = ST_HALT;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM process 3: output logic
    // ------------------------------------------------------------------------
    // commit is combinational so the single-cycle datapath writes in the same
    // cycle the instruction is presented. Reset forces it low immediately.
    always_comb begin
        w_commit = 1'b0;
        if (!rst) begin
            case (r_state)
                ST_RUN:  w_commit = !halt && !w_bp_match;
                ST_STEP: w_commit = !halt;
                default: w_commit = 1'b0;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Step counter, breakpoint bookkeeping
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_remaining <= 8'd0;
            r_skip_bp   <= 1'b0;
            r_bp_hit    <= 1'b0;
        end else begin
            // step_num is captured only on the step pulse.
            if ((r_state == ST_HALT) && step) begin
                r_remaining <= step_load(step_num);
            end else if ((r_state == ST_STEP) && w_commit) begin
                r_remaining <= r_remaining - 8'd1;
            end

            if ((r_state == ST_HALT) && !step && run) begin
                r_skip_bp <= 1'b1;
            end else if (r_state == ST_RUN) begin
                r_skip_bp <= 1'b0;
            end

            if (w_leave_halt) begin
                r_bp_hit <= 1'b0;
            end else if ((r_state == ST_RUN) && !halt && w_bp_match) begin
                r_bp_hit <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Architectural PC and retired-instruction counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur_pc    <= RESET_PC;
            r_instr_cnt <= '0;
        end else if (w_commit) begin
            r_cur_pc    <= {next_pc[31:2], 2'b00};
            r_instr_cnt <= r_instr_cnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign cur_pc    = r_cur_pc;
    assign commit    = w_commit;
    assign state     = r_state;
    assign bp_hit    = r_bp_hit;
    assign instr_cnt = r_instr_cnt;

endmodule : pc_step_ctrl

// File: tb/tb_pc_step_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pc_step_ctrl
//
// Self-checking bench for pc_step_ctrl with a narrow (4-bit) retired counter
// so wrap-around is reachable. A behavioural model of the debug controller
// predicts commit, PC, mode, breakpoint flag and count for every cycle; a
// directed sequence covers the documented scenarios and a randomized phase
// mixes pulses, breakpoints, PC jumps and resets.
// ----------------------------------------------------------------------------
module tb_pc_step_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      next_pc;
    logic             run;
    logic             step;
    logic             halt;
    logic [7:0]       step_num;
    logic             bp_en;
    logic [31:0]      bp_addr;
    logic [31:0]      cur_pc;
    logic             commit;
    logic [1:0]       state;
    logic             bp_hit;
    logic [CNT_W-1:0] instr_cnt;

    always #5 clk = ~clk;

    pc_step_ctrl #(
        .RESET_PC (32'h0000_0000),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .next_pc   (next_pc),
        .run       (run),
        .step      (step),
        .halt      (halt),
        .step_num  (step_num),
        .bp_en     (bp_en),
        .bp_addr   (bp_addr),
        .cur_pc    (cur_pc),
        .commit    (commit),
        .state     (state),
        .bp_hit    (bp_hit),
        .instr_cnt (instr_cnt)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: mode 0=halted, 1=running, 2=stepping.
    logic [31:0]      m_pc;
    logic [CNT_W-1:0] m_cnt;
    int               m_mode;
    int               m_left;
    bit               m_skip;
    bit               m_bphit;

    logic             tb_bp_en;
    logic [31:0]      tb_bp_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_cnt   = '0;
        m_mode  = 0;
        m_left  = 0;
        m_skip  = 1'b0;
        m_bphit = 1'b0;
    endtask

    // One clock cycle: drive inputs at the falling edge, check outputs just
    // after, then advance the model across the rising edge.
    task automatic cyc(input bit r, input bit ru, input bit st, input bit ha,
                       input logic [7:0] num, input logic [31:0] npc);
        bit exp_c;
        bit match;
        // NOTE: bench inputs use blocking assignments from procedural code so
        // they settle well before the DUT samples them on the next edge.
        rst      = r;
        run      = ru;
        step     = st;
        halt     = ha;
        step_num = num;
        next_pc  = npc;
        bp_en    = tb_bp_en;
        bp_addr  = tb_bp_addr;
        #1;
        match = (m_mode == 1) && tb_bp_en && (m_pc[31:2] == tb_bp_addr[31:2]) && !m_skip;
        case (m_mode)
            1:       exp_c = !ha && !match;
            2:       exp_c = !ha;
            default: exp_c = 1'b0;
        endcase
        if (r) exp_c = 1'b0;

        check("commit",    {31'd0, commit}, {31'd0, exp_c});
        check("cur_pc",    cur_pc, m_pc);
        check("state",     {30'd0, state}, 32'(m_mode));
        check("bp_hit",    {31'd0, bp_hit}, {31'd0, m_bphit});
        check("instr_cnt", 32'(instr_cnt), 32'(m_cnt));

        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            if (exp_c) begin
                m_pc  = {npc[31:2], 2'b00};
                m_cnt = m_cnt + 1'b1;
            end
            case (m_mode)
                0: begin
                    if (st) begin
                        m_mode  = 2;
                        m_left  = (num == 8'd0) ? 1 : int'(num);
                        m_bphit = 1'b0;
                    end else if (ru) begin
                        m_mode  = 1;
                        m_skip  = 1'b1;
                        m_bphit = 1'b0;
                    end
                end
                1: begin
                    m_skip = 1'b0;
                    if (ha) begin
                        m_mode = 0;
                    end else if (match) begin
                        m_mode  = 0;
                        m_bphit = 1'b1;
                    end
                end
                default: begin
                    if (ha) begin
                        m_mode = 0;
                    end else begin
                        m_left--;
                        if (m_left == 0) m_mode = 0;
                    end
                end
            endcase
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 8'd0, m_pc + 32'd4);
    endtask

    logic [CNT_W-1:0] cnt_before;

    initial begin
        rst        = 1'b1;
        run        = 1'b0;
        step       = 1'b0;
        halt       = 1'b0;
        step_num   = 8'd0;
        next_pc    = 32'd0;
        tb_bp_en   = 1'b0;
        tb_bp_addr = 32'd0;
        bp_en      = 1'b0;
        bp_addr    = 32'd0;
        model_reset();
        @(negedge clk);
        @(negedge clk);

        // Idle after reset: everything stays at reset values.
        idle(5);
        check("idle_pc",  cur_pc, 32'h0);
        check("idle_cnt", 32'(instr_cnt), 32'd0);

        // Step of three instructions.
        cyc(0, 0, 1, 0, 8'd3, m_pc + 32'd4);
        idle(4);
        check("step3_pc",    cur_pc, 32'h0000_000C);
        check("step3_cnt",   32'(instr_cnt), 32'd3);
        check("step3_state", {30'd0, state}, 32'd0);

        // Run into a breakpoint at 0x10, then resume past it.
        cyc(1, 0, 0, 0, 8'd0, 32'd0);
        tb_bp_en   = 1'b1;
        tb_bp_addr = 32'h0000_0010;
        cyc(0, 1, 0, 0, 8'd0, m_pc + 32'd4);
        idle(6);
        check("bp_pc",  cur_pc, 32'h0000_0010);
        check("bp_hit", {31'd0, bp_hit}, 32'd1);
        cyc(0, 1, 0, 0, 8'd0, m_pc + 32'd4);
        idle(1);
        cyc(0, 0, 0, 1, 8'd0, m_pc + 32'd4);
        check("resume_pc",  cur_pc, 32'h0000_0014);
        check("resume_hit", {31'd0, bp_hit}, 32'd0);

        // Halt pulse in RUN at 0x20.
        tb_bp_en = 1'b0;
        cyc(0, 1, 0, 0, 8'd0, m_pc + 32'd4);
        idle(3);
        cyc(0, 0, 0, 1, 8'd0, m_pc + 32'd4);
        idle(2);
        check("halt_pc", cur_pc, 32'h0000_0020);

        // Step of five interrupted by halt after two commits.
        cnt_before = m_cnt;
        cyc(0, 0, 1, 0, 8'd5, m_pc + 32'd4);
        idle(2);
        cyc(0, 0, 0, 1, 8'd0, m_pc + 32'd4);
        idle(1);
        check("step_halt_pc",  cur_pc, 32'h0000_0028);
        check("step_halt_cnt", 32'(instr_cnt), 32'(CNT_W'(cnt_before + 2)));

        // run and step together with step_num=0: one stepped instruction.
        cyc(0, 1, 1, 0, 8'd0, m_pc + 32'd4);
        idle(2);
        check("runstep_pc",    cur_pc, 32'h0000_002C);
        check("runstep_state", {30'd0, state}, 32'd0);

        // Counter wrap, then reset in the middle of RUN.
        cyc(1, 0, 0, 0, 8'd0, 32'd0);
        cyc(0, 1, 0, 0, 8'd0, m_pc + 32'd4);
        idle(15);
        check("wrap15_cnt", 32'(instr_cnt), 32'd15);
        idle(1);
        check("wrap0_cnt",   32'(instr_cnt), 32'd0);
        check("wrap_pc",     cur_pc, 32'h0000_0040);
        check("wrap_state",  {30'd0, state}, 32'd1);
        cyc(1, 0, 0, 0, 8'd0, m_pc + 32'd4);
        check("rst_run_pc",    cur_pc, 32'h0);
        check("rst_run_state", {30'd0, state}, 32'd0);

        // Randomized phase.
        for (int i = 0; i < 400; i++) begin
            bit          r, ru, st, ha;
            logic [7:0]  num;
            logic [31:0] npc;
            if ($urandom_range(0, 19) == 0) begin
                tb_bp_en   = 1'($urandom);
                tb_bp_addr = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
            end
            r   = ($urandom_range(0, 59) == 0);
            ru  = ($urandom_range(0, 7) == 0);
            st  = ($urandom_range(0, 9) == 0);
            ha  = ($urandom_range(0, 11) == 0);
            num = 8'($urandom_range(0, 6));
            npc = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 127)) : m_pc + 32'd4;
            cyc(r, ru, st, ha, num, npc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_pc_step_ctrl
